// File: rtl/stack_ctrl.sv
// Operand-stack sequencer for an 8-entry register file: one opcode per 2 cycles.
// state | meaning: IDLE = accept opcode, EXEC = apply latched op against depth.
module stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int SEL_W  = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [2:0]        i_op_code,
  input  logic [DATA_W-1:0] i_op_imm,
  input  logic              i_clr_err,
  output logic [SEL_W-1:0]  o_rf_re_sel_a,
  output logic [SEL_W-1:0]  o_rf_re_sel_b,
  input  logic [DATA_W-1:0] i_rf_re_data_a,
  input  logic [DATA_W-1:0] i_rf_re_data_b,
  output logic [SEL_W-1:0]  o_rf_wr_sel_a,
  output logic [SEL_W-1:0]  o_rf_wr_sel_b,
  output logic [DATA_W-1:0] o_rf_wr_data_a,
  output logic [DATA_W-1:0] o_rf_wr_data_b,
  output logic              o_rf_wr_en_a,
  output logic              o_rf_wr_en_b,
  output logic [SEL_W:0]    o_depth,
  output logic [DATA_W-1:0] o_tos_data,
  output logic              o_tos_valid,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_pop_valid,
  output logic              o_err_ovf,
  output logic              o_err_udf
);

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_DUP, OP_SWAP, OP_ADD, OP_SUB, OP_AND
  } op_t;

  localparam logic [SEL_W:0] FULL = (SEL_W+1)'(DEPTH);
  localparam logic [SEL_W:0] ONE  = (SEL_W+1)'(1);
  localparam logic [SEL_W:0] TWO  = (SEL_W+1)'(2);

  state_t              r_state, w_state_nxt;
  op_t                 r_op;
  logic [DATA_W-1:0]   r_imm;
  logic [SEL_W:0]      r_depth, w_depth_nxt;
  logic [DATA_W-1:0]   r_pop_data;
  logic                r_pop_valid;
  logic                r_err_ovf, r_err_udf;

  logic [SEL_W-1:0]    w_sel_a, w_sel_b;
  logic [DATA_W-1:0]   w_tos, w_nos, w_alu;
  logic                w_we_a, w_we_b;
  logic [SEL_W-1:0]    w_ws_a;
  logic [DATA_W-1:0]   w_wd_a;
  logic                w_set_ovf, w_set_udf, w_pop;

  // Wrapped selects at depth 0/1 are never consumed by a legal op.
  assign w_sel_a = r_depth[SEL_W-1:0] - SEL_W'(1);
  assign w_sel_b = r_depth[SEL_W-1:0] - SEL_W'(2);
  assign w_tos   = i_rf_re_data_a;
  assign w_nos   = i_rf_re_data_b;

  always_comb begin
    w_alu = w_nos & w_tos;
    case (r_op)
      OP_ADD:  w_alu = w_nos + w_tos;
      OP_SUB:  w_alu = w_nos - w_tos;
      default: w_alu = w_nos & w_tos;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_we_a      = 1'b0;
    w_we_b      = 1'b0;
    w_ws_a      = r_depth[SEL_W-1:0];
    w_wd_a      = r_imm;
    w_set_ovf   = 1'b0;
    w_set_udf   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: if (i_op_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_state_nxt = ST_IDLE;
        case (r_op)
          OP_NOP: ;
          OP_PUSH: begin
            if (r_depth < FULL) begin
              w_we_a      = 1'b1;
              w_depth_nxt = r_depth + ONE;
            end else w_set_ovf = 1'b1;
          end
          OP_POP: begin
            if (r_depth != '0) begin
              w_pop       = 1'b1;
              w_depth_nxt = r_depth - ONE;
            end else w_set_udf = 1'b1;
          end
          OP_DUP: begin
            if (r_depth == '0) w_set_udf = 1'b1;
            else if (r_depth == FULL) w_set_ovf = 1'b1;
            else begin
              w_we_a      = 1'b1;
              w_wd_a      = w_tos;
              w_depth_nxt = r_depth + ONE;
            end
          end
          OP_SWAP: begin
            if (r_depth >= TWO) begin
              w_we_a = 1'b1;
              w_we_b = 1'b1;
              w_ws_a = w_sel_a;
              w_wd_a = w_nos;
            end else w_set_udf = 1'b1;
          end
          default: begin
            if (r_depth >= TWO) begin
              w_we_a      = 1'b1;
              w_ws_a      = w_sel_b;
              w_wd_a      = w_alu;
              w_depth_nxt = r_depth - ONE;
            end else w_set_udf = 1'b1;
          end
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_imm       <= '0;
      r_depth     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_depth     <= w_depth_nxt;
      r_pop_valid <= w_pop;
      if (w_pop) r_pop_data <= w_tos;
      if (r_state == ST_IDLE && i_op_valid) begin
        r_op  <= op_t'(i_op_code);
        r_imm <= i_op_imm;
      end
      // A new error in the same cycle as a clear wins.
      r_err_ovf <= (r_err_ovf & ~i_clr_err) | w_set_ovf;
      r_err_udf <= (r_err_udf & ~i_clr_err) | w_set_udf;
    end
  end

  assign o_op_ready     = (r_state == ST_IDLE);
  assign o_rf_re_sel_a  = w_sel_a;
  assign o_rf_re_sel_b  = w_sel_b;
  assign o_rf_wr_sel_a  = w_ws_a;
  assign o_rf_wr_sel_b  = w_sel_b;
  assign o_rf_wr_data_a = w_wd_a;
  assign o_rf_wr_data_b = w_tos;
  assign o_rf_wr_en_a   = w_we_a & ~i_reset;
  assign o_rf_wr_en_b   = w_we_b & ~i_reset;
  assign o_depth        = r_depth;
  assign o_tos_data     = i_rf_re_data_a;
  assign o_tos_valid    = (r_depth != '0);
  assign o_pop_data     = r_pop_data;
  assign o_pop_valid    = r_pop_valid;
  assign o_err_ovf      = r_err_ovf;
  assign o_err_udf      = r_err_udf;

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer that runs the 8-entry, 8-bit register file as an operand stack for the stack machine.
- Accepts one opcode at a time through a valid/ready handshake and keeps the stack depth.
- Drives the register file's two read selects and two write ports; read data returns combinationally.
- Executes PUSH/POP/DUP/SWAP/ADD/SUB/AND; flags overflow/underflow instead of corrupting the stack.

Parameters:
- DATA_W, 8, stack word width (equals register file width)
- DEPTH, 8, stack entries (equals register count; power of two)
- SEL_W, 3, register select width, log2(DEPTH)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  opcode offered
- op_ready  out  1  controller can accept an opcode
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 AND
- op_imm  in  DATA_W  PUSH operand
- clr_err  in  1  clears sticky error flags
- rf_re_sel_a  out  SEL_W  read select, top of stack (TOS)
- rf_re_sel_b  out  SEL_W  read select, next on stack (NOS)
- rf_re_data_a  in  DATA_W  register file read data A (combinational)
- rf_re_data_b  in  DATA_W  register file read data B (combinational)
- rf_wr_sel_a / rf_wr_sel_b  out  SEL_W  write selects
- rf_wr_data_a / rf_wr_data_b  out  DATA_W  write data
- rf_wr_en_a / rf_wr_en_b  out  1  write enables; the register file commits on the clock edge
- depth  out  SEL_W+1  current entry count, 0..DEPTH
- tos_data  out  DATA_W  equals rf_re_data_a
- tos_valid  out  1  depth != 0
- pop_data  out  DATA_W  value removed by the last POP (registered)
- pop_valid  out  1  one-cycle pulse after a successful POP
- err_ovf / err_udf  out  1  sticky overflow / underflow flags

Behaviour:
- Reset values:
  - state IDLE, depth 0, op_ready 1
  - all wr_en 0, pop_valid 0, pop_data 0, err_ovf 0, err_udf 0
  - register file contents are not cleared; depth 0 makes them logically empty.
- Read selects, every cycle:
  - rf_re_sel_a = (depth-1) mod DEPTH
  - rf_re_sel_b = (depth-2) mod DEPTH
  - wrapped values at depth 0 or 1 are don't-care and must not be consumed.
- FSM, two states:
  - IDLE: op_ready=1. On op_valid, latch op_code and op_imm and go to EXEC.
  - EXEC: op_ready=0. Evaluate the latched op against depth, drive writes combinationally, update depth on the edge, return to IDLE.
  - Throughput is 1 op per 2 cycles. An op accepted at edge N has its writes, depth and flags visible after edge N+1.
- Op rules (T=TOS, S=NOS, d=depth; arithmetic mod 2^DATA_W, no carry):
  - NOP: no write.
  - PUSH: needs d<DEPTH. Port A writes sel d, data imm; d+1.
  - POP: needs d>=1. pop_data<=T, pop_valid pulses in the following cycle; d-1.
  - DUP: needs 1<=d<DEPTH. Port A writes sel d, data T; d+1.
  - SWAP: needs d>=2. Port A writes sel d-1, data S; port B writes sel d-2, data T; d unchanged.
  - ADD/SUB/AND: needs d>=2. Port A writes sel d-2, data S+T / S-T / S&T; d-1.
- Precondition failure:
  - no write enable, depth unchanged.
  - PUSH or DUP at d=DEPTH sets err_ovf; all other failures set err_udf.
  - The FSM still returns to IDLE.
- Port B is enabled only by SWAP. Port A and port B never target the same select.
- Error flags:
  - sticky until reset or clr_err.
  - If clr_err and a new error occur in the same cycle, the flag ends set.
- Reset during EXEC: write enables forced 0 that cycle, op aborted, all state returns to reset values.
- op_valid while op_ready=0 is ignored. The requester must hold op_valid until it sees op_ready.

Test Plan:
- Reset, then PUSH 0x11, PUSH 0x22 -> depth=2, tos_data=0x22, register 1 = 0x22, no errors.
- From [0x11,0x22]: ADD -> depth=1, register 0 = 0x33. Then PUSH 0x40, SUB -> register 0 = 0xF3 (0x33-0x40 wraps).
- From [0x11,0x22]: SWAP -> register 0 = 0x22, register 1 = 0x11, both write enables high for exactly one cycle. Then POP -> pop_data=0x11, pop_valid pulses once, depth=1.
- 8 PUSHes then a 9th PUSH 0xAA -> depth stays 8, err_ovf=1, no write enable. Then clr_err -> err_ovf=0.
- From depth 0: POP, then ADD -> err_udf=1, depth=0, no writes, op_ready returns to 1 after each op.
- Reset asserted in the EXEC cycle of PUSH 0x55 -> no write enable that cycle, depth=0, state IDLE, op_ready=1 on the next cycle.
